mem_write_monitor: RTL and testbench
====================================

Name: mem_write_monitor

Overview:
- Synthesizable, parametrised write-bus checker that watches the processor data-memory write port (MemWrite, DataAdr, WriteData).
- Compares observed stores in order against a loaded table of expected (address, data) pairs, with an optional ignored scratch address and a watchdog timeout.
- Produces a sticky pass/fail verdict with failure diagnostics.
- Sits beside the top-level core in simulation and FPGA self-test builds.

Parameters:
- ADDR_W, 32, width of DataAdr and of the expected-address entries
- DATA_W, 32, width of WriteData and of the expected-data entries
- DEPTH, 4, maximum number of expected writes in the table (power of two, ≥2)
- IGNORE_EN, 1, when 1, writes to IGNORE_ADDR are skipped silently
- IGNORE_ADDR, 96, scratch address excluded from checking
- TIMEOUT, 1024, cycles allowed in RUN without a matched write before failing

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: flush table, return to IDLE
- exp_valid  in  1  expected-entry push request
- exp_ready  out  1  table accepts a push this cycle
- exp_addr  in  ADDR_W  expected store address
- exp_data  in  DATA_W  expected store data
- start  in  1  begin checking
- MemWrite  in  1  core store strobe
- DataAdr  in  ADDR_W  core store address
- WriteData  in  DATA_W  core store data
- busy  out  1  state == RUN
- done  out  1  verdict reached (PASS or FAIL)
- pass  out  1  all entries matched
- fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- fail_addr  out  ADDR_W  DataAdr of offending write (0 on timeout)
- fail_data  out  DATA_W  WriteData of offending write (0 on timeout)
- match_count  out  $clog2(DEPTH+1)  entries matched so far

Behaviour:
- Reset (async) or clear (sync):
  - State goes to IDLE and the table is emptied.
  - All outputs 0 except exp_ready = 1.
  - clear has priority over every other input.
- Table:
  - Circular FIFO of DEPTH entries with read pointer rd, write pointer wr and count cnt.
  - exp_ready = (state == IDLE) && (cnt < DEPTH).
  - A push occurs on exp_valid && exp_ready.
  - Pushes are refused (exp_ready = 0) when the table is full or the state is not IDLE.
- States and transitions:
  - IDLE → RUN on start && cnt > 0. start with cnt == 0 is ignored.
  - RUN: the store bus is sampled on every rising edge where MemWrite = 1.
    - Skip when IGNORE_EN && DataAdr == IGNORE_ADDR. No pop; the timeout counter is not reset.
    - Match when DataAdr == head.addr && WriteData == head.data:
      - Pop the head, increment match_count, reset the timeout counter.
      - If this was the last entry (cnt == 1), go to PASS.
    - Otherwise go to FAIL:
      - fail_code = 1 if the address differs, else 2.
      - Capture DataAdr/WriteData into fail_addr/fail_data.
  - Timeout:
    - The counter increments every RUN cycle without a match.
    - When it reaches TIMEOUT-1 with no match that cycle, go to FAIL with fail_code = 3.
    - A match on that same cycle wins.
  - PASS/FAIL are sticky until reset or clear. Further MemWrite activity is ignored; start is ignored.
- Outputs:
  - All outputs are registered.
  - The verdict is visible on the cycle after the deciding edge: done = 1, pass = 1 in PASS, and busy drops together with done rising.
- Width rules:
  - Comparisons are full-width and exact.
  - The timeout counter is $clog2(TIMEOUT) bits and saturates, never wraps.
- Simultaneous events:
  - exp_valid during RUN is not accepted.
  - start in the same cycle as the final push: the pushed entry counts (cnt includes the push).
- Reset asserted mid-RUN aborts immediately, with no verdict.

Decomposition:
- Package mon_pkg holds:
  - typedef enum {IDLE, RUN, PASS, FAIL} mon_state_t
  - fail-code constants FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT
- Sub-module exp_fifo (parametrised DEPTH/width circular buffer with push/pop/count) holds the table. The FSM, comparison and timeout live in the top module.

Test Plan:
- Push (100,7), start, core writes (96,3) then (100,7) → (96,3) skipped; done = 1, pass = 1, match_count = 1 on the cycle after the (100,7) edge.
- Push (100,7), start, core writes (104,7) → FAIL, fail_code = 1, fail_addr = 104, fail_data = 7.
- Push (100,7), start, core writes (100,8) → fail_code = 2, fail_data = 8.
- TIMEOUT = 16, push one entry, start, no writes → done on cycle 16 of RUN, fail_code = 3, fail_addr = 0.
- DEPTH = 4:
  - Push 5 entries → exp_ready falls after 4, the 5th is refused.
  - Run 4 matching writes in order → pass = 1, match_count = 4.
- Assert reset mid-RUN after 2 matches → all outputs 0, exp_ready = 1. Then start with an empty table → stays IDLE.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared types for the data-memory write monitor: checker states and failure codes.
package mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} mon_state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/exp_fifo.sv
// Circular table of expected (address, data) store pairs with push, pop and occupancy count.
module exp_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while cnt covers them.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            addr_mem[wr_q] <= push_addr;
            data_mem[wr_q] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_q];
    assign head_data = data_mem[rd_q];
    assign cnt       = cnt_q;

endmodule

// File: rtl/mem_write_monitor.sv
// Checks core stores in order against a loaded table of expected writes and
// reports a sticky pass/fail verdict with diagnostics of the offending store.
module mem_write_monitor
    import mon_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 4,
    parameter bit          IGNORE_EN   = 1'b1,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(96),
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic                       start,
    input  logic                       MemWrite,
    input  logic [ADDR_W-1:0]          DataAdr,
    input  logic [DATA_W-1:0]          WriteData,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 fail_code,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data,
    output logic [$clog2(DEPTH+1)-1:0] match_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mon_state_t        state_q, state_d;
    logic [CW-1:0]     mc_q, mc_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        fc_q, fc_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;

    logic              push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     cnt;
    logic              skip, addr_hit, data_hit;

    exp_fifo #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_addr (exp_addr),
        .push_data (exp_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .cnt       (cnt)
    );

    assign exp_ready = (state_q == IDLE) && (cnt < CW'(DEPTH));
    assign push      = exp_valid && exp_ready;

    assign skip     = MemWrite && IGNORE_EN && (DataAdr == IGNORE_ADDR);
    assign addr_hit = (DataAdr == head_addr);
    assign data_hit = (WriteData == head_data);

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        tmo_d   = tmo_q;
        fc_d    = fc_q;
        fa_d    = fa_q;
        fd_d    = fd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A push in the same cycle as start already counts as an entry.
                if (start && ((cnt != '0) || push)) begin
                    state_d = RUN;
                    tmo_d   = '0;
                end
            end
            RUN: begin
                if (MemWrite && !skip) begin
                    if (addr_hit && data_hit) begin
                        pop   = 1'b1;
                        mc_d  = mc_q + 1'b1;
                        tmo_d = '0;
                        if (cnt == CW'(1)) state_d = PASS;
                    end else begin
                        state_d = FAIL;
                        fc_d    = addr_hit ? FC_DATA : FC_ADDR;
                        fa_d    = DataAdr;
                        fd_d    = WriteData;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = FAIL;
                    fc_d    = FC_TIMEOUT;
                    fa_d    = '0;
                    fd_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mc_q    <= '0;
            tmo_q   <= '0;
            fc_q    <= FC_NONE;
            fa_q    <= '0;
            fd_q    <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            mc_q    <= '0;
            tmo_q   <= '0;
            fc_q    <= FC_NONE;
            fa_q    <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            tmo_q   <= tmo_d;
            fc_q    <= fc_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == PASS) || (state_q == FAIL);
    assign pass        = (state_q == PASS);
    assign fail_code   = fc_q;
    assign fail_addr   = fa_q;
    assign fail_data   = fd_q;
    assign match_count = mc_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Randomised and directed bench for mem_write_monitor against a queue-based model of the checker.
module tb_mem_write_monitor;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    logic        exp_ready, busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] fail_addr, fail_data;
    logic [2:0]  match_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    mem_write_monitor #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH       (DEPTH),
        .IGNORE_EN   (1'b1),
        .IGNORE_ADDR (32'd96),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .start       (start),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of outstanding expectations plus verdict variables.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_run = 0, m_done = 0, m_pass = 0;
    logic [1:0]  m_fc = 0;
    logic [31:0] m_fa = 0, m_fd = 0;
    int          m_mc = 0, m_idle = 0;

    function automatic void model_clear();
        mq.delete();
        m_run = 0; m_done = 0; m_pass = 0;
        m_fc = 0; m_fa = 0; m_fd = 0;
        m_mc = 0; m_idle = 0;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset || clear) begin
            model_clear();
        end else if (!m_run && !m_done) begin
            if (exp_valid && mq.size() < DEPTH) mq.push_back('{exp_addr, exp_data});
            if (start && mq.size() > 0) begin
                m_run  = 1;
                m_idle = 0;
            end
        end else if (m_run) begin
            if (MemWrite && DataAdr != 32'd96) begin
                if (DataAdr == mq[0].a && WriteData == mq[0].d) begin
                    void'(mq.pop_front());
                    m_mc++;
                    m_idle = 0;
                    if (mq.size() == 0) begin
                        m_run = 0; m_done = 1; m_pass = 1;
                    end
                end else begin
                    m_run = 0; m_done = 1;
                    m_fc  = (DataAdr != mq[0].a) ? 2'd1 : 2'd2;
                    m_fa  = DataAdr;
                    m_fd  = WriteData;
                end
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_run = 0; m_done = 1; m_fc = 2'd3; m_fa = 0; m_fd = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("exp_ready", exp_ready, (!m_run && !m_done && mq.size() < DEPTH));
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("fail_code", fail_code, m_fc);
            chk("fail_addr", fail_addr, m_fa);
            chk("fail_data", fail_data, m_fd);
            chk("match_count", match_count, m_mc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1; exp_addr = a; exp_data = d;
        tick();
        exp_valid = 0;
    endtask

    task automatic start1();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        int n;
        int r;
        bit stall;
        repeat (2) tick();
        reset = 0;
        check_en = 1;
        chk("reset_ready", exp_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_mc", match_count, 0);

        // Ignored scratch write then a matching store.
        push1(100, 7);
        start1();
        wr(96, 3);
        chk("skip_busy", busy, 1);
        wr(100, 7);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_mc", match_count, 1);

        do_clear();
        push1(100, 7);
        start1();
        wr(104, 7);
        chk("t2_code", fail_code, 1);
        chk("t2_addr", fail_addr, 104);
        chk("t2_data", fail_data, 7);

        do_clear();
        push1(100, 7);
        start1();
        wr(100, 8);
        chk("t3_code", fail_code, 2);
        chk("t3_data", fail_data, 8);

        do_clear();
        push1(100, 7);
        start1();
        repeat (TIMEOUT - 1) tick();
        chk("t4_busy_before", busy, 1);
        chk("t4_done_before", done, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_code", fail_code, 3);
        chk("t4_addr", fail_addr, 0);

        // Five pushes into a four-entry table; the fifth is refused.
        do_clear();
        for (int i = 0; i < 5; i++) begin
            chk("t5_ready", exp_ready, (i < 4) ? 1 : 0);
            exp_valid = 1; exp_addr = 200 + 4 * i; exp_data = i;
            tick();
        end
        exp_valid = 0;
        start1();
        for (int i = 0; i < 4; i++) wr(200 + 4 * i, i);
        chk("t5_pass", pass, 1);
        chk("t5_mc", match_count, 4);

        // Reset mid-RUN after two matches.
        do_clear();
        for (int i = 0; i < 4; i++) push1(300 + 4 * i, 10 + i);
        start1();
        wr(300, 10);
        wr(304, 11);
        chk("t6_mc", match_count, 2);
        #2 reset = 1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_mc0", match_count, 0);
        chk("t6_ready", exp_ready, 1);
        tick();
        reset = 0;
        start1();
        chk("t6_idle", busy, 0);

        for (int it = 0; it < 150; it++) begin
            do_clear();
            n = $urandom_range(1, DEPTH);
            stall = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < n; j++) begin
                exp_valid = 1;
                exp_addr  = 100 + 4 * $urandom_range(0, 3);
                exp_data  = $urandom_range(0, 3);
                if (j == n - 1 && $urandom_range(0, 1) == 1) start = 1;
                tick();
                exp_valid = 0;
            end
            if (!start) start1();
            start = 0;
            for (int c = 0; c < 60 && !m_done; c++) begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    clear = 1;
                end else if (!stall && r < 12 && mq.size() > 0) begin
                    MemWrite  = 1;
                    DataAdr   = mq[0].a ^ (($urandom_range(0, 9) == 0) ? 32'd4 : 32'd0);
                    WriteData = mq[0].d ^ (($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
                end else if (r < 14) begin
                    MemWrite  = 1;
                    DataAdr   = 96;
                    WriteData = $urandom;
                end else if (r == 14) begin
                    exp_valid = 1; exp_addr = $urandom; exp_data = $urandom; start = 1;
                end
                tick();
                MemWrite = 0; exp_valid = 0; start = 0; clear = 0;
            end
            for (int k = 0; k < 3; k++) begin
                MemWrite = 1; DataAdr = $urandom_range(90, 120); WriteData = $urandom;
                start = 1;
                tick();
            end
            MemWrite = 0; start = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
